// File: rtl/msi_int_pkg.sv
// MSI responder shared definitions: state encoding, parameter defaults, counter widths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package msi_int_pkg;

    localparam int VEC_W_DEF       = 32;
    localparam int MAX_RETRY_DEF   = 3;
    localparam int TIMEOUT_CYC_DEF = 1024;
    localparam int GAP_CYC_DEF     = 4;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        ISSUE,
        WAIT,
        GAP,
        NEXT,
        HOLD
    } msi_state_t;

    // Width of a counter that must hold values 0..n-1 (never below 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Wait timer width: counts cycles spent waiting for the core response.
    function automatic int tmr_w(input int timeout_cyc);
        return cnt_w(timeout_cyc);
    endfunction

    // Retry counter width: holds 0..max_retry.
    function automatic int rty_w(input int max_retry);
        return cnt_w(max_retry + 1);
    endfunction

endpackage

// File: rtl/msi_lsb_enc.sv
// Lowest-set-bit priority encoder: index of the least significant 1 in vec_i.
// Latency: combinational.
// Backpressure: none; vld_o is low when vec_i is all zeros (idx_o is then 0).
//   vec_i  : candidate request bits
//   idx_o  : index of the lowest set bit
//   vld_o  : at least one bit set
module msi_lsb_enc
    import msi_int_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]          vec_i,
    output logic [cnt_w(W)-1:0]   idx_o,
    output logic                  vld_o
);

    localparam int IW = cnt_w(W);

    // Scan from the top down so the last hit, the lowest bit, wins.
    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
            end
        end
        vld_o = |vec_i;
    end

endmodule

// File: rtl/msi_int_resp.sv
// MSI request responder: serialises a captured request vector into one-hot core pulses,
// with retry/timeout per vector and one batch-level sent/fail pulse back to the requester.
// Latency: capture to first core pulse 2 cycles; last core response to batch pulse 2 cycles.
// Backpressure: one vector outstanding at the core; new requests wait until the batch pulse.
//   user_clk, reset            : clock, async active-high reset
//   cfg_msi_enable             : MSI enable from config space (registered to int_msi_enb)
//   msi_int_user               : level request vector, held by the requester until sent/fail
//   int_msi_sent/int_msi_fail  : one-cycle batch result pulses
//   cfg_interrupt_msi_int      : one-hot one-cycle request pulse to the core
//   cfg_interrupt_msi_sent/fail: core acknowledge/reject for the outstanding vector
//   msi_busy, msi_drop_cnt, msi_timeout : status
module msi_int_resp
    import msi_int_pkg::*;
#(
    parameter int VEC_W       = VEC_W_DEF,
    parameter int MAX_RETRY   = MAX_RETRY_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF
) (
    input  logic             user_clk,
    input  logic             reset,
    input  logic             cfg_msi_enable,
    input  logic [VEC_W-1:0] msi_int_user,
    output logic             int_msi_enb,
    output logic             int_msi_sent,
    output logic             int_msi_fail,
    output logic [VEC_W-1:0] cfg_interrupt_msi_int,
    input  logic             cfg_interrupt_msi_sent,
    input  logic             cfg_interrupt_msi_fail,
    output logic             msi_busy,
    output logic [15:0]      msi_drop_cnt,
    output logic             msi_timeout
);

    localparam int IDX_W = cnt_w(VEC_W);
    localparam int TMR_W = tmr_w(TIMEOUT_CYC);
    localparam int RTY_W = rty_w(MAX_RETRY);
    localparam int GAP_W = cnt_w(GAP_CYC);

    // Timeout is decided one cycle before the timer would show TIMEOUT_CYC-1, so that the
    // registered msi_timeout pulse lands exactly TIMEOUT_CYC cycles after the issue pulse.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 2);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [VEC_W-1:0] ONE      = VEC_W'(1);

    msi_state_t       state_q;
    logic [VEC_W-1:0] pend_q;
    logic [IDX_W-1:0] cur_q;
    logic [RTY_W-1:0] retry_q;
    logic [TMR_W-1:0] timer_q;
    logic [GAP_W-1:0] gap_q;
    logic             fail_flag_q;
    logic             enb_q;
    logic             sent_q;
    logic             fail_q;
    logic [VEC_W-1:0] msi_int_q;
    logic [15:0]      drop_q;
    logic             timeout_q;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_vld;

    logic [16:0]      drop_sum_one;
    logic [16:0]      drop_sum_all;
    logic [15:0]      drop_one_d;
    logic [15:0]      drop_all_d;
    logic             abort_d;

    msi_lsb_enc #(
        .W (VEC_W)
    ) u_enc (
        .vec_i (pend_q),
        .idx_o (enc_idx),
        .vld_o (enc_vld)
    );

    // Saturating drop counter increments: one vector, or every remaining vector on abort.
    assign drop_sum_one = {1'b0, drop_q} + 17'd1;
    assign drop_sum_all = {1'b0, drop_q} + 17'($countones(pend_q));
    assign drop_one_d   = drop_sum_one[16] ? 16'hFFFF : drop_sum_one[15:0];
    assign drop_all_d   = drop_sum_all[16] ? 16'hFFFF : drop_sum_all[15:0];

    // MSI disabled while vectors are in flight. A batch only starts with enable high, so a
    // low registered enable in these states means it fell during the batch. NEXT is left
    // out so the abort cannot re-enter itself; it re-triggers from SEL if bits remain.
    assign abort_d = !enb_q && (state_q == SEL || state_q == ISSUE ||
                                state_q == WAIT || state_q == GAP);

    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            cur_q       <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            fail_flag_q <= 1'b0;
            enb_q       <= 1'b0;
            sent_q      <= 1'b0;
            fail_q      <= 1'b0;
            msi_int_q   <= '0;
            drop_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            enb_q     <= cfg_msi_enable;
            sent_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            msi_int_q <= '0;

            if (abort_d) begin
                // Any in-flight core response is simply never looked at again.
                pend_q      <= '0;
                fail_flag_q <= 1'b1;
                drop_q      <= drop_all_d;
                state_q     <= NEXT;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (enb_q && (|msi_int_user)) begin
                            pend_q      <= msi_int_user;
                            fail_flag_q <= 1'b0;
                            state_q     <= SEL;
                        end
                    end
                    SEL: begin
                        retry_q <= '0;
                        if (enc_vld) begin
                            // Pulse is raised on entry to ISSUE so it is visible only there.
                            cur_q     <= enc_idx;
                            msi_int_q <= ONE << enc_idx;
                            state_q   <= ISSUE;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                    ISSUE: begin
                        timer_q <= '0;
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        if (cfg_interrupt_msi_sent) begin
                            pend_q[cur_q] <= 1'b0;
                            state_q       <= NEXT;
                        end else if (cfg_interrupt_msi_fail || timer_q == TMR_LAST) begin
                            timeout_q <= !cfg_interrupt_msi_fail;
                            if (retry_q < RTY_MAX) begin
                                retry_q <= retry_q + 1'b1;
                                gap_q   <= '0;
                                state_q <= GAP;
                            end else begin
                                pend_q[cur_q] <= 1'b0;
                                fail_flag_q   <= 1'b1;
                                drop_q        <= drop_one_d;
                                state_q       <= NEXT;
                            end
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_q == GAP_LAST) begin
                            msi_int_q <= ONE << cur_q;
                            state_q   <= ISSUE;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                    NEXT: begin
                        if (|pend_q) begin
                            state_q <= SEL;
                        end else begin
                            fail_q  <= fail_flag_q;
                            sent_q  <= !fail_flag_q;
                            state_q <= HOLD;
                        end
                    end
                    HOLD: begin
                        // One cycle for the requester to drop its vector before recapture.
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign int_msi_enb           = enb_q;
    assign int_msi_sent          = sent_q;
    assign int_msi_fail          = fail_q;
    assign cfg_interrupt_msi_int = msi_int_q;
    assign msi_busy              = (state_q != IDLE);
    assign msi_drop_cnt          = drop_q;
    assign msi_timeout           = timeout_q;

endmodule

// File: tb/tb_msi_int_resp.sv
// Bench for msi_int_resp: table-driven batches, hand sequences for disable/reset, and
// randomised batches against an event-level reference model.
// Latency/backpressure: a core responder model answers each pulse per a response list.
module tb_msi_int_resp;

    localparam int VEC_W       = 32;
    localparam int MAX_RETRY   = 3;
    localparam int TIMEOUT_CYC = 1024;
    localparam int GAP_CYC     = 4;

    // Core response kinds for each issued pulse.
    localparam int K_ACK    = 0;
    localparam int K_NAK    = 1;
    localparam int K_BOTH   = 2;
    localparam int K_SILENT = 3;

    typedef struct {
        int          cyc;
        logic [31:0] vec;
    } ev_t;

    typedef struct {
        logic [31:0] vec;
        logic [31:0] pol;     // 2-bit response kind per pulse, pulse 0 in bits [1:0]
        int          dly;
        int          np;      // expected number of core pulses
        int          bad;     // 1 = int_msi_fail expected, 0 = int_msi_sent
        int          drop;    // expected drop count increase
        int          nto;     // expected number of timeout pulses
    } vec_t;

    logic        user_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_msi_enable = 1'b0;
    logic [31:0] msi_int_user = '0;
    logic        core_sent = 1'b0;
    logic        core_fail = 1'b0;
    logic        int_msi_enb, int_msi_sent, int_msi_fail, msi_busy, msi_timeout;
    logic [31:0] cfg_interrupt_msi_int;
    logic [15:0] msi_drop_cnt;

    msi_int_resp #(
        .VEC_W       (VEC_W),
        .MAX_RETRY   (MAX_RETRY),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .GAP_CYC     (GAP_CYC)
    ) dut (
        .user_clk               (user_clk),
        .reset                  (reset),
        .cfg_msi_enable         (cfg_msi_enable),
        .msi_int_user           (msi_int_user),
        .int_msi_enb            (int_msi_enb),
        .int_msi_sent           (int_msi_sent),
        .int_msi_fail           (int_msi_fail),
        .cfg_interrupt_msi_int  (cfg_interrupt_msi_int),
        .cfg_interrupt_msi_sent (core_sent),
        .cfg_interrupt_msi_fail (core_fail),
        .msi_busy               (msi_busy),
        .msi_drop_cnt           (msi_drop_cnt),
        .msi_timeout            (msi_timeout)
    );

    always #5 user_clk = ~user_clk;

    int cyc = 0;
    always @(posedge user_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    ev_t obs_p[$];
    ev_t exp_p[$];
    int  obs_to[$];
    int  exp_to[$];
    int  pol_q[$];
    int  mdl_pol[$];
    int  obs_sent_n = 0;
    int  obs_fail_n = 0;
    int  obs_resp_cyc = -1;
    int  dly_g = 3;
    int  cd = 0;
    int  cd_kind = K_ACK;
    int  exp_drop_total = 0;
    ev_t mon_e;
    int  mon_kind;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor and core responder, both working at the falling edge.
    always @(negedge user_clk) begin
        core_sent = 1'b0;
        core_fail = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                core_sent = (cd_kind == K_ACK || cd_kind == K_BOTH);
                core_fail = (cd_kind == K_NAK || cd_kind == K_BOTH);
            end
        end
        if (cfg_interrupt_msi_int != 0) begin
            mon_e.cyc = cyc;
            mon_e.vec = cfg_interrupt_msi_int;
            obs_p.push_back(mon_e);
            check("pulse onehot", $countones(cfg_interrupt_msi_int), 1);
            mon_kind = (pol_q.size() > 0) ? pol_q.pop_front() : K_ACK;
            if (mon_kind != K_SILENT) begin
                cd      = dly_g;
                cd_kind = mon_kind;
            end
        end
        if (msi_timeout) obs_to.push_back(cyc);
        if (int_msi_sent) begin obs_sent_n++; obs_resp_cyc = cyc; end
        if (int_msi_fail) begin obs_fail_n++; obs_resp_cyc = cyc; end
    end

    // Event-level model: walks the vector bit by bit, consuming one response per pulse.
    // Timing rules: first pulse 2 cycles after capture; after an ack the next pulse is 3
    // cycles later; after a reject GAP_CYC idle cycles precede the retry; a silent core
    // times out so the timeout pulse is TIMEOUT_CYC after the issue; batch pulse comes 2
    // cycles after the final decision.
    task automatic model(input logic [31:0] vec, input int c0, input int dly,
                         output int resp_cyc, output int resp_bad, output int drops);
        logic [31:0] pend;
        int t, dec, k, cur, kind;
        bit done;
        ev_t e;
        pend = vec; t = c0 + 2; k = 0; resp_bad = 0; drops = 0;
        exp_p.delete(); exp_to.delete();
        while (pend != 0) begin
            cur = 0;
            while (!pend[cur]) cur++;
            done = 0;
            for (int a = 0; a <= MAX_RETRY && !done; a++) begin
                e.cyc = t; e.vec = 32'h1 << cur;
                exp_p.push_back(e);
                kind = (k < mdl_pol.size()) ? mdl_pol[k] : K_ACK;
                k++;
                if (kind == K_ACK || kind == K_BOTH) begin
                    dec = t + dly; pend[cur] = 1'b0; done = 1;
                end else begin
                    if (kind == K_SILENT) begin
                        dec = t + TIMEOUT_CYC - 1;
                        exp_to.push_back(t + TIMEOUT_CYC);
                    end else begin
                        dec = t + dly;
                    end
                    if (a == MAX_RETRY) begin
                        pend[cur] = 1'b0; resp_bad = 1; drops++; done = 1;
                    end
                end
                t = done ? dec + 3 : dec + GAP_CYC + 1;
            end
        end
        resp_cyc = t - 1;
    endtask

    task automatic clear_obs();
        obs_p.delete(); obs_to.delete();
        obs_sent_n = 0; obs_fail_n = 0; obs_resp_cyc = -1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (msi_busy && n < 5000) begin @(negedge user_clk); n++; end
        check("idle before batch", n < 5000, 1);
    endtask

    task automatic wait_resp(output int at);
        int n;
        n = 0;
        while (!(int_msi_sent || int_msi_fail) && n < 20000) begin @(negedge user_clk); n++; end
        check("batch response seen", n < 20000, 1);
        at = cyc;
        msi_int_user = '0;
    endtask

    task automatic run_batch(input logic [31:0] vec, input int dly, output int c0);
        int at;
        wait_idle();
        clear_obs();
        dly_g = dly;
        @(negedge user_clk);
        msi_int_user = vec;
        c0 = cyc;
        wait_resp(at);
        repeat (3) @(negedge user_clk);
    endtask

    task automatic compare_model(input string tag, input logic [31:0] vec, input int c0, input int dly);
        int rc, rb, dr;
        model(vec, c0, dly, rc, rb, dr);
        check({tag, " pulse count"}, obs_p.size(), exp_p.size());
        for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
            check({tag, " pulse cycle"}, obs_p[i].cyc, exp_p[i].cyc);
            check({tag, " pulse vector"}, obs_p[i].vec, exp_p[i].vec);
        end
        check({tag, " timeout count"}, obs_to.size(), exp_to.size());
        for (int i = 0; i < exp_to.size() && i < obs_to.size(); i++)
            check({tag, " timeout cycle"}, obs_to[i], exp_to[i]);
        check({tag, " response cycle"}, obs_resp_cyc, rc);
        check({tag, " sent pulses"}, obs_sent_n, rb ? 0 : 1);
        check({tag, " fail pulses"}, obs_fail_n, rb ? 1 : 0);
        exp_drop_total = (exp_drop_total + dr > 65535) ? 65535 : exp_drop_total + dr;
        check({tag, " drop count"}, msi_drop_cnt, exp_drop_total);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    vec_t        tbl[5];
    logic [31:0] pw;
    logic [31:0] rv;
    int          c0, d0, t0, at, rd, rr, rk;

    initial begin
        tbl[0] = '{vec: 32'h0000_0005, pol: 32'h0000_0000, dly: 3, np: 2, bad: 0, drop: 0, nto: 0};
        tbl[1] = '{vec: 32'h8000_0000, pol: 32'h0000_0005, dly: 3, np: 3, bad: 0, drop: 0, nto: 0};
        tbl[2] = '{vec: 32'h0000_0002, pol: 32'h5555_5555, dly: 2, np: 4, bad: 1, drop: 1, nto: 0};
        tbl[3] = '{vec: 32'h0000_0010, pol: 32'h0000_0002, dly: 2, np: 1, bad: 0, drop: 0, nto: 0};
        tbl[4] = '{vec: 32'h0000_0001, pol: 32'hFFFF_FFFF, dly: 3, np: 4, bad: 1, drop: 1, nto: 4};

        // Reset state.
        repeat (3) @(negedge user_clk);
        check("reset int_msi_enb", int_msi_enb, 0);
        check("reset msi_busy", msi_busy, 0);
        check("reset msi_int", cfg_interrupt_msi_int, 0);
        check("reset drop_cnt", msi_drop_cnt, 0);
        check("reset sent/fail/timeout", {int_msi_sent, int_msi_fail, msi_timeout}, 0);
        reset = 1'b0;

        // Disabled: a request must not be captured.
        msi_int_user = 32'h3;
        repeat (6) @(negedge user_clk);
        check("disabled no capture busy", msi_busy, 0);
        check("disabled no pulses", obs_p.size(), 0);
        msi_int_user = '0;

        // Enable is seen one cycle later.
        cfg_msi_enable = 1'b1;
        check("enb before delay", int_msi_enb, 0);
        @(negedge user_clk);
        check("enb after delay", int_msi_enb, 1);

        // Zero vector: nothing happens.
        repeat (5) @(negedge user_clk);
        check("zero vector idle", msi_busy, 0);

        // Table-driven batches.
        for (int i = 0; i < 5; i++) begin
            pol_q.delete(); mdl_pol.delete();
            pw = tbl[i].pol;
            for (int j = 0; j < 16; j++) begin
                pol_q.push_back(int'(pw[2*j +: 2]));
                mdl_pol.push_back(int'(pw[2*j +: 2]));
            end
            d0 = msi_drop_cnt;
            run_batch(tbl[i].vec, tbl[i].dly, c0);
            check("tbl pulse count", obs_p.size(), tbl[i].np);
            check("tbl fail pulse", obs_fail_n, tbl[i].bad);
            check("tbl sent pulse", obs_sent_n, 1 - tbl[i].bad);
            check("tbl drop delta", int'(msi_drop_cnt) - d0, tbl[i].drop);
            check("tbl timeout count", obs_to.size(), tbl[i].nto);
            compare_model("tbl", tbl[i].vec, c0, tbl[i].dly);
        end

        // Disable after the first ack: remaining three bits dropped, no further pulses.
        pol_q.delete(); pol_q.push_back(K_ACK);
        wait_idle();
        clear_obs();
        dly_g = 3;
        d0 = msi_drop_cnt;
        @(negedge user_clk);
        msi_int_user = 32'hF;
        c0 = cyc;
        rd = 0;
        while (cfg_interrupt_msi_int == 0 && rd < 100) begin @(negedge user_clk); rd++; end
        check("dis first pulse cycle", cyc, c0 + 2);
        t0 = cyc;
        repeat (4) @(negedge user_clk);
        cfg_msi_enable = 1'b0;
        wait_resp(at);
        check("dis response cycle", at, t0 + 7);
        check("dis fail pulse", int_msi_fail, 1);
        repeat (20) @(negedge user_clk);
        check("dis pulse count", obs_p.size(), 1);
        check("dis drop delta", int'(msi_drop_cnt) - d0, 3);
        check("dis sent pulses", obs_sent_n, 0);
        check("dis fail pulses", obs_fail_n, 1);
        check("dis enb low", int_msi_enb, 0);
        exp_drop_total += 3;
        cfg_msi_enable = 1'b1;
        repeat (2) @(negedge user_clk);

        // Reset while waiting on a silent core.
        pol_q.delete(); pol_q.push_back(K_SILENT);
        wait_idle();
        clear_obs();
        @(negedge user_clk);
        msi_int_user = 32'h10;
        rd = 0;
        while (cfg_interrupt_msi_int == 0 && rd < 100) begin @(negedge user_clk); rd++; end
        repeat (5) @(negedge user_clk);
        check("rst busy in wait", msi_busy, 1);
        reset = 1'b1;
        msi_int_user = '0;
        @(negedge user_clk);
        check("rst mid enb", int_msi_enb, 0);
        check("rst mid busy", msi_busy, 0);
        check("rst mid drop_cnt", msi_drop_cnt, 0);
        check("rst mid outputs", {int_msi_sent, int_msi_fail, msi_timeout, cfg_interrupt_msi_int}, 0);
        @(negedge user_clk);
        reset = 1'b0;
        exp_drop_total = 0;
        repeat (10) @(negedge user_clk);
        check("rst no response", obs_sent_n + obs_fail_n, 0);
        check("rst no new pulse", obs_p.size(), 1);

        // Randomised batches against the model.
        for (int r = 0; r < 8; r++) begin
            rv = $urandom & $urandom & $urandom;
            if (rv == 0) rv = 32'h1 << $urandom_range(31, 0);
            rd = $urandom_range(5, 1);
            pol_q.delete(); mdl_pol.delete();
            for (int i = 0; i < 160; i++) begin
                rr = $urandom_range(99, 0);
                rk = (rr < 55) ? K_ACK : (rr < 90) ? K_NAK : K_BOTH;
                pol_q.push_back(rk);
                mdl_pol.push_back(rk);
            end
            run_batch(rv, rd, c0);
            compare_model("rand", rv, c0, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msi_int_resp.md
Name: msi_int_resp

Overview:
PCI_TRX-side responder for the per-direction MSI request handshake. It accepts the 32-bit level request vector from a DMA interrupt requester and serialises it into single-vector one-cycle pulses toward the PCIe core's MSI interface. It collects the core's sent/fail responses, applies bounded retry and timeout, and returns one batch-level sent or fail pulse to the requester. One instance sits per requester, between the DMA TX/RX interrupt logic and the PCIe hard core.

Parameters:
VEC_W, 32, width of the MSI vector field.
MAX_RETRY, 3, re-issues of one vector after core fail before the vector is dropped.
TIMEOUT_CYC, 1024, cycles to wait for core sent/fail before treating the vector as failed.
GAP_CYC, 4, idle cycles between a core fail and the retry of that vector.

Ports:
user_clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
cfg_msi_enable  in  1  MSI enable from PCIe core config space.
msi_int_user  in  VEC_W  request vector from requester; held until int_msi_sent/int_msi_fail.
int_msi_enb  out  1  registered copy of cfg_msi_enable, sent to requester.
int_msi_sent  out  1  one-cycle pulse: whole captured batch delivered.
int_msi_fail  out  1  one-cycle pulse: batch done, at least one vector dropped.
cfg_interrupt_msi_int  out  VEC_W  one-hot, one-cycle request pulse to core.
cfg_interrupt_msi_sent  in  1  core acknowledge for the outstanding vector.
cfg_interrupt_msi_fail  in  1  core reject for the outstanding vector.
msi_busy  out  1  FSM not in IDLE.
msi_drop_cnt  out  16  saturating count of dropped vectors.
msi_timeout  out  1  one-cycle pulse on each timeout event.

Behaviour:
- Reset: all outputs 0; pending=0; retry=0; timer=0; state IDLE.
- int_msi_enb is cfg_msi_enable delayed by 1 cycle.
- IDLE:
  - if int_msi_enb=1 and msi_int_user≠0, capture pend<=msi_int_user, clear fail_flag, go SEL.
  - msi_int_user changes outside IDLE are ignored until the batch response has been issued.
- SEL: cur = lowest set bit of pend; retry=0; go ISSUE.
- ISSUE: drive cfg_interrupt_msi_int = one-hot(cur) for exactly 1 cycle; timer=0; go WAIT.
- WAIT: timer increments each cycle.
  - sent=1: clear pend[cur] and go NEXT. sent has priority if sent and fail arrive in the same cycle.
  - fail=1, or timer reaches TIMEOUT_CYC-1:
    - msi_timeout pulses on the timeout case only.
    - if retry<MAX_RETRY: retry++, go GAP.
    - otherwise clear pend[cur], set fail_flag, msi_drop_cnt++ (saturates at 0xFFFF), go NEXT.
  - A sent/fail pulse arriving outside WAIT is ignored.
- GAP: count GAP_CYC cycles, then go ISSUE with the same cur.
- NEXT:
  - if pend≠0, go SEL.
  - otherwise pulse int_msi_fail if fail_flag=1, else pulse int_msi_sent (exactly one of the two, for 1 cycle), then go HOLD.
- HOLD: 1 cycle, letting the requester clear its vector before a recapture; then go IDLE.
- Latency, vector capture to first core pulse: 2 cycles (IDLE→SEL→ISSUE registered output).
- MSI disable mid-batch: int_msi_enb falling in any state other than IDLE/HOLD drops every remaining pend bit (drop_cnt += popcount, saturating), sets fail_flag and goes NEXT. An in-flight core response is discarded.
- Reset mid-operation: immediate return to reset values; no response pulse is generated.
- Exactly one vector is outstanding at the core at any time; cfg_interrupt_msi_int is 0 outside ISSUE.

Decomposition:
- Package msi_int_pkg holds:
  - state enum (IDLE, SEL, ISSUE, WAIT, GAP, NEXT, HOLD);
  - VEC_W default;
  - the counter widths: timer $clog2(TIMEOUT_CYC), retry $clog2(MAX_RETRY+1).
- Sub-module msi_lsb_enc: combinational lowest-set-bit priority encoder, VEC_W in, index + valid out. Shared with future multi-channel arbiters.

Test Plan:
- Vector 0x0000_0005, core sends sent 3 cycles after each pulse -> pulses 0x1 then 0x4; one int_msi_sent pulse; int_msi_fail never asserted; drop_cnt=0.
- Vector 0x8000_0000, core fail twice, then sent -> three pulses of 0x8000_0000, GAP_CYC=4 idle cycles between them; int_msi_sent pulses once.
- Vector 0x2, core always fails -> 4 pulses (1+MAX_RETRY); int_msi_fail pulses once; drop_cnt=1.
- Vector 0x1, core silent -> msi_timeout pulses at TIMEOUT_CYC cycles after each issue, 4 times; int_msi_fail pulses; drop_cnt=1.
- Vector 0xF, deassert cfg_msi_enable after the first sent -> remaining 3 bits dropped, drop_cnt=3, int_msi_fail pulses, cfg_interrupt_msi_int stays 0 afterwards.
- Simultaneous sent and fail in WAIT for vector 0x10 -> treated as sent, no retry; assert reset during WAIT -> all outputs 0 next cycle, no response pulse.
